// File: rtl/tx_64b66b_gearbox.sv
// tx_64b66b_gearbox: 66-bit block to 32-bit SERDES word transmit gearbox.
// Blocks are sent header first, then payload[63] down to payload[0], and
// idle blocks are inserted whenever the buffer needs a block and none is
// offered. Optional macro TX_64B66B_SCRAMBLE_EN enables the x^58+x^39+1
// payload scrambler. Headers are never scrambled.
module tx_64b66b_gearbox #(
  parameter logic [63:0] IDLE_PAYLOAD = 64'h000000000000001E
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_header,
  input  logic [63:0] in_payload,
  output logic [31:0] tx_data,
  output logic        idle_inserted,
  output logic        hdr_err
);

  // Residual bit count and left-aligned residual buffer (oldest bit at [65]).
  logic [6:0]  r_q;
  logic [6:0]  r_next;
  logic [65:0] res_q;
  logic [65:0] res_next;
  logic        ready_q;

  // Block chosen for loading this cycle, before and after scrambling.
  logic [1:0]  blk_hdr;
  logic [63:0] blk_raw;
  logic [63:0] blk_pay;

  // Residual bits followed by the new block, MSB-first.
  logic [97:0] merged;
  logic [31:0] tx_next;
  logic        hdr_bad;

  // ready_q always equals (r_q < 32); tx_rst masks it so nothing is accepted
  // while reset is held, yet it is high in the very first cycle afterwards.
  assign in_ready = ready_q & ~tx_rst;

  assign hdr_bad = (in_header == 2'b00) || (in_header == 2'b11);

  // Select the offered block, or an idle control block when none is offered.
  always_comb begin
    blk_hdr = 2'b10;
    blk_raw = IDLE_PAYLOAD;
    if (in_valid) begin
      blk_hdr = in_header;
      blk_raw = in_payload;
    end
  end

`ifdef TX_64B66B_SCRAMBLE_EN
  logic [57:0] scr_q;
  logic [57:0] scr_next;

  // Self-synchronous scrambler applied serially, payload[63] first.
  always_comb begin
    logic [57:0] s;
    logic        o;
    s       = scr_q;
    o       = 1'b0;
    blk_pay = '0;
    for (int i = 63; i >= 0; i--) begin
      o          = blk_raw[i] ^ s[38] ^ s[57];
      blk_pay[i] = o;
      s          = {s[56:0], o};
    end
    scr_next = s;
  end

  // Scrambler state advances only when a block is loaded.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      scr_q <= 58'h3FF_FFFF_FFFF_FFFF;
    end else if (ready_q) begin
      scr_q <= scr_next;
    end
  end
`else
  assign blk_pay = blk_raw;
`endif

  // Emit the oldest 32 bits; on a load the new block lands right behind the
  // residual bits, so its first bit can already appear in this word.
  always_comb begin
    merged = {res_q[65:34], 66'd0} | ({blk_hdr, blk_pay, 32'd0} >> r_q);
    if (ready_q) begin
      tx_next  = merged[97:66];
      res_next = merged[65:0];
      r_next   = r_q + 7'd34;
    end else begin
      tx_next  = res_q[65:34];
      res_next = {res_q[33:0], 32'd0};
      r_next   = r_q - 7'd32;
    end
  end

  // State and registered outputs; reset discards any partial block.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      r_q           <= '0;
      res_q         <= '0;
      ready_q       <= 1'b1;
      tx_data       <= '0;
      idle_inserted <= 1'b0;
      hdr_err       <= 1'b0;
    end else begin
      r_q           <= r_next;
      res_q         <= res_next;
      ready_q       <= (r_next < 7'd32);
      tx_data       <= tx_next;
      idle_inserted <= ready_q & ~in_valid;
      hdr_err       <= ready_q & in_valid & hdr_bad;
    end
  end

endmodule

// File: tb/tb_tx_64b66b_gearbox.sv
// tb_tx_64b66b_gearbox: scoreboard bench for tx_64b66b_gearbox. Every block
// the model loads is pushed as 66 bits onto a bit queue; each output word is
// popped from that queue and compared against tx_data.
module tb_tx_64b66b_gearbox;

  logic        tx_clk = 1'b0;
  logic        tx_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_header = 2'b00;
  logic [63:0] in_payload = '0;
  logic [31:0] tx_data;
  logic        idle_inserted;
  logic        hdr_err;

  int n_checks = 0;
  int n_fail = 0;

  bit          sbq[$];
  logic [57:0] seed_m;
  logic [31:0] exp_data;
  logic        exp_ready;
  logic        obs_ready;
  logic        exp_idle;
  logic        exp_herr;
  logic        underflow;

  tx_64b66b_gearbox dut (
    .tx_clk(tx_clk),
    .tx_rst(tx_rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_header(in_header),
    .in_payload(in_payload),
    .tx_data(tx_data),
    .idle_inserted(idle_inserted),
    .hdr_err(hdr_err)
  );

  // Free-running transmit clock.
  always #5 tx_clk = ~tx_clk;

  // Drive one cycle, update the reference model and sample #1 after the edge.
  task automatic tick(input logic rst, input logic v, input logic [1:0] h, input logic [63:0] p);
    logic [1:0]  hh;
    logic [63:0] pp;
    logic        o;
    tx_rst = rst;
    in_valid = v;
    in_header = h;
    in_payload = p;
    #1;
    obs_ready = in_ready;
    exp_ready = !rst && (sbq.size() < 32);
    exp_idle = 1'b0;
    exp_herr = 1'b0;
    exp_data = '0;
    underflow = 1'b0;
    if (rst) begin
      sbq.delete();
      seed_m = 58'h3FF_FFFF_FFFF_FFFF;
    end else if (sbq.size() < 32) begin
      if (v) begin
        hh = h;
        pp = p;
        exp_herr = (h == 2'b00) || (h == 2'b11);
      end else begin
        hh = 2'b10;
        pp = 64'h000000000000001E;
        exp_idle = 1'b1;
      end
`ifdef TX_64B66B_SCRAMBLE_EN
      for (int i = 63; i >= 0; i--) begin
        o = pp[i] ^ seed_m[38] ^ seed_m[57];
        pp[i] = o;
        seed_m = {seed_m[56:0], o};
      end
`endif
      sbq.push_back(hh[1]);
      sbq.push_back(hh[0]);
      for (int i = 63; i >= 0; i--) sbq.push_back(pp[i]);
    end
    @(posedge tx_clk);
    #1;
    if (!rst) begin
      if (sbq.size() < 32) begin
        underflow = 1'b1;
      end else begin
        for (int i = 31; i >= 0; i--) exp_data[i] = sbq.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
      n_checks++;
      if (tx_data !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_tx_data: got %h expected %h", tx_data, 32'h0);
      end
      n_checks++;
      if (obs_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_in_ready: got %b expected 0", obs_ready);
      end
      n_checks++;
      if ({idle_inserted, hdr_err} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL reset_flags: got %b expected 00", {idle_inserted, hdr_err});
      end
    end
  endtask

  task automatic test_idle_fill();
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 2'b00, 64'h0);
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL idle_in_ready cyc %0d: got %b expected %b", i, obs_ready, exp_ready);
      end
      n_checks++;
      if (underflow || tx_data !== exp_data) begin
        n_fail++;
        $display("[TB] FAIL idle_tx_data cyc %0d: got %h expected %h (underflow %b)", i, tx_data, exp_data, underflow);
      end
      n_checks++;
      if ({idle_inserted, hdr_err} !== {exp_idle, exp_herr}) begin
        n_fail++;
        $display("[TB] FAIL idle_flags cyc %0d: got %b expected %b", i, {idle_inserted, hdr_err}, {exp_idle, exp_herr});
      end
`ifndef TX_64B66B_SCRAMBLE_EN
      if (i == 0) begin
        n_checks++;
        if (tx_data !== 32'h8000_0000) begin
          n_fail++;
          $display("[TB] FAIL idle_first_word: got %h expected %h", tx_data, 32'h8000_0000);
        end
      end
`endif
    end
  endtask

  task automatic test_stream();
    logic [1:0]  bh;
    logic [63:0] bp;
    int          n_rdy;
    int          n_idle;
    n_rdy = 0;
    n_idle = 0;
    tick(1'b1, 1'b0, 2'b00, 64'h0);
    bh = 2'b01;
    bp = {$urandom, $urandom};
    for (int i = 0; i < 66; i++) begin
      tick(1'b0, 1'b1, bh, bp);
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL stream_in_ready cyc %0d: got %b expected %b", i, obs_ready, exp_ready);
      end
      n_checks++;
      if (underflow || tx_data !== exp_data) begin
        n_fail++;
        $display("[TB] FAIL stream_tx_data cyc %0d: got %h expected %h (underflow %b)", i, tx_data, exp_data, underflow);
      end
      if (idle_inserted) n_idle++;
      if (obs_ready) begin
        n_rdy++;
        bh = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        bp = {$urandom, $urandom};
      end
    end
    n_checks++;
    if (n_rdy !== 32) begin
      n_fail++;
      $display("[TB] FAIL stream_ready_count: got %0d expected 32", n_rdy);
    end
    n_checks++;
    if (n_idle !== 0) begin
      n_fail++;
      $display("[TB] FAIL stream_idle_count: got %0d expected 0", n_idle);
    end
  endtask

  task automatic test_hdr_err();
    bit accepted;
    int n_herr;
    accepted = 1'b0;
    n_herr = 0;
    for (int i = 0; i < 40; i++) begin
      if (!accepted) tick(1'b0, 1'b1, 2'b11, 64'hFFFF_0000_FFFF_0000);
      else tick(1'b0, 1'b0, 2'b00, 64'h0);
      if (obs_ready) accepted = 1'b1;
      if (hdr_err) n_herr++;
      n_checks++;
      if (underflow || tx_data !== exp_data) begin
        n_fail++;
        $display("[TB] FAIL hdr_tx_data cyc %0d: got %h expected %h (underflow %b)", i, tx_data, exp_data, underflow);
      end
      n_checks++;
      if ({idle_inserted, hdr_err} !== {exp_idle, exp_herr}) begin
        n_fail++;
        $display("[TB] FAIL hdr_flags cyc %0d: got %b expected %b", i, {idle_inserted, hdr_err}, {exp_idle, exp_herr});
      end
    end
    n_checks++;
    if (n_herr !== 1) begin
      n_fail++;
      $display("[TB] FAIL hdr_err_count: got %0d expected 1", n_herr);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] bp;
    bit          found;
    found = 1'b0;
    bp = {$urandom, $urandom};
    for (int i = 0; i < 100 && !found; i++) begin
      if (sbq.size() == 30) begin
        found = 1'b1;
      end else begin
        tick(1'b0, 1'b1, 2'b01, bp);
        if (obs_ready) bp = {$urandom, $urandom};
        n_checks++;
        if (underflow || tx_data !== exp_data) begin
          n_fail++;
          $display("[TB] FAIL mid_tx_data cyc %0d: got %h expected %h (underflow %b)", i, tx_data, exp_data, underflow);
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL mid_reach_r30: got no R=30 cycle expected one within 100 cycles");
    end
    tick(1'b1, 1'b1, 2'b01, bp);
    n_checks++;
    if (tx_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_tx_data: got %h expected %h", tx_data, 32'h0);
    end
    for (int i = 0; i < 10; i++) begin
      bp = {$urandom, $urandom};
      tick(1'b0, 1'b1, 2'b01, bp);
      if (i == 0) begin
        n_checks++;
        if (obs_ready !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL mid_ready_after_reset: got %b expected 1", obs_ready);
        end
        n_checks++;
        if (tx_data[31:30] !== 2'b01) begin
          n_fail++;
          $display("[TB] FAIL mid_fresh_header: got %b expected 01", tx_data[31:30]);
        end
      end
      n_checks++;
      if (underflow || tx_data !== exp_data) begin
        n_fail++;
        $display("[TB] FAIL mid_after_tx_data cyc %0d: got %h expected %h (underflow %b)", i, tx_data, exp_data, underflow);
      end
    end
  endtask

  // Sequence the scenarios and report.
  initial begin
    seed_m = 58'h3FF_FFFF_FFFF_FFFF;
    test_reset();
    test_idle_fill();
    test_stream();
    test_hdr_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a run that never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
